// File: rtl/stepper_position_ctrl.sv
// Stepper motion controller: decodes MOVE/HOME/STOP commands and drives step/dir/enable
// with a fixed pulse width and direction setup time. It also tracks absolute position and homing.
module stepper_position_ctrl #(
  parameter int unsigned STEP_DIV  = 100000,
  parameter int unsigned PULSE_W   = 200,
  parameter int unsigned DIR_SETUP = 100,
  parameter int unsigned POS_MAX   = 4000,
  parameter int unsigned HOME_MAX  = 8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  input  logic        limit_switch,
  output logic        step,
  output logic        dir,
  output logic        enable,
  output logic [31:0] status
);

  localparam int unsigned HCW = $clog2(HOME_MAX + 1);
  localparam logic [31:0] DIR_LAST  = 32'(DIR_SETUP - 1);
  localparam logic [31:0] HI_LAST   = 32'(PULSE_W - 1);
  localparam logic [31:0] LO_LAST   = 32'(STEP_DIV - PULSE_W - 1);
  localparam logic [31:0] PER_LAST  = 32'(STEP_DIV - 1);
  localparam logic [31:0] PULSE_W_C = 32'(PULSE_W);
  localparam logic [15:0] POS_MAX_C = 16'(POS_MAX);
  localparam logic [HCW-1:0] HOME_MAX_C = HCW'(HOME_MAX);
  localparam logic [HCW-1:0] HOME_ONE   = HCW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIR_SET = 3'd1,
    S_STEP_HI = 3'd2,
    S_STEP_LO = 3'd3,
    S_HOMING  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [15:0]    pos_q, pos_d, target_q, target_d;
  logic [HCW-1:0] home_cnt_q, home_cnt_d;
  logic           dir_q, dir_d, step_q, step_d, enable_q, enable_d, busy_q, busy_d;
  logic           homed_q, homed_d, fault_q, fault_d, limit_hit_q, limit_hit_d;
  logic           cmd_err_q, cmd_err_d, homing_q, homing_d, stop_q, stop_d;

  logic           is_move, is_home, is_stop, limit_evt, moving;
  logic [15:0]    tgt_clamp;
  logic           unused_cmd_bits;

  function automatic logic [15:0] next_pos(input logic [15:0] p, input logic up);
    logic [15:0] r;
    r = p;
    if (up) begin
      if (p < POS_MAX_C) r = p + 16'd1;
      else               r = p;
    end else begin
      if (p != 16'd0) r = p - 16'd1;
      else            r = p;
    end
    return r;
  endfunction

  assign is_move   = cmd_valid && (cmd_data[31:30] == 2'b01);
  assign is_home   = cmd_valid && (cmd_data[31:30] == 2'b10);
  assign is_stop   = cmd_valid && (cmd_data[31:30] == 2'b11);
  assign tgt_clamp = (cmd_data[15:0] > POS_MAX_C) ? POS_MAX_C : cmd_data[15:0];
  assign unused_cmd_bits = ^cmd_data[29:16];
  assign moving    = (state_q == S_DIR_SET) || (state_q == S_STEP_HI) ||
                     (state_q == S_STEP_LO) || (state_q == S_HOMING);
  // A limit taken at a period boundary swallows any command strobed in that cycle.
  assign limit_evt = ((state_q == S_STEP_LO) && (cnt_q == LO_LAST) && !dir_q && limit_switch) ||
                     ((state_q == S_HOMING) && (cnt_q == PER_LAST) && limit_switch);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    target_d    = target_q;
    home_cnt_d  = home_cnt_q;
    dir_d       = dir_q;
    enable_d    = enable_q;
    homed_d     = homed_q;
    fault_d     = fault_q;
    limit_hit_d = limit_hit_q;
    cmd_err_d   = cmd_err_q;
    homing_d    = homing_q;
    stop_d      = stop_q;

    case (state_q)
      S_IDLE: begin
        if (is_move) begin
          if (!homed_q) begin
            cmd_err_d = 1'b1;
          end else begin
            cmd_err_d   = 1'b0;
            limit_hit_d = 1'b0;
            if (tgt_clamp != pos_q) begin
              target_d = tgt_clamp;
              dir_d    = (tgt_clamp > pos_q);
              homing_d = 1'b0;
              stop_d   = 1'b0;
              cnt_d    = 32'd0;
              state_d  = S_DIR_SET;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (is_home) begin
          cmd_err_d   = 1'b0;
          limit_hit_d = 1'b0;
          dir_d       = 1'b0;
          homed_d     = 1'b0;
          homing_d    = 1'b1;
          stop_d      = 1'b0;
          cnt_d       = 32'd0;
          state_d     = S_DIR_SET;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIR_SET: begin
        if (cnt_q == DIR_LAST) begin
          cnt_d = 32'd0;
          if (stop_q || (!homing_q && (target_q == pos_q))) begin
            homing_d = 1'b0;
            state_d  = S_IDLE;
          end else if (homing_q) begin
            home_cnt_d = HOME_ONE;
            state_d    = S_HOMING;
          end else begin
            pos_d   = next_pos(pos_q, dir_q);
            state_d = S_STEP_HI;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STEP_HI: begin
        if (cnt_q == HI_LAST) begin
          cnt_d   = 32'd0;
          state_d = S_STEP_LO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STEP_LO: begin
        if (cnt_q == LO_LAST) begin
          cnt_d = 32'd0;
          if (!dir_q && limit_switch) begin
            pos_d       = 16'd0;
            limit_hit_d = 1'b1;
            state_d     = S_IDLE;
          end else if (stop_q || (target_q == pos_q)) begin
            state_d = S_IDLE;
          end else if ((target_q > pos_q) != dir_q) begin
            dir_d   = (target_q > pos_q);
            state_d = S_DIR_SET;
          end else begin
            pos_d   = next_pos(pos_q, dir_q);
            state_d = S_STEP_HI;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HOMING: begin
        if (cnt_q == PER_LAST) begin
          cnt_d = 32'd0;
          if (limit_switch) begin
            pos_d    = 16'd0;
            homed_d  = 1'b1;
            homing_d = 1'b0;
            state_d  = S_IDLE;
          end else if (stop_q) begin
            homing_d = 1'b0;
            state_d  = S_IDLE;
          end else if (home_cnt_q >= HOME_MAX_C) begin
            fault_d  = 1'b1;
            enable_d = 1'b0;
            homing_d = 1'b0;
            state_d  = S_FAULT;
          end else begin
            home_cnt_d = home_cnt_q + HOME_ONE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_FAULT: begin
        if (is_home) begin
          enable_d    = 1'b1;
          fault_d     = 1'b0;
          cmd_err_d   = 1'b0;
          limit_hit_d = 1'b0;
          dir_d       = 1'b0;
          homed_d     = 1'b0;
          homing_d    = 1'b1;
          stop_d      = 1'b0;
          cnt_d       = 32'd0;
          state_d     = S_DIR_SET;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Commands arriving mid-motion are only latched; the period-end logic acts on them.
    if (moving && !limit_evt) begin
      if (is_move) begin
        if (homing_q) begin
          cmd_err_d = 1'b1;
        end else begin
          target_d    = tgt_clamp;
          stop_d      = 1'b0;
          cmd_err_d   = 1'b0;
          limit_hit_d = 1'b0;
        end
      end else if (is_home) begin
        cmd_err_d = 1'b1;
      end else if (is_stop) begin
        stop_d      = 1'b1;
        cmd_err_d   = 1'b0;
        limit_hit_d = 1'b0;
      end else begin
        stop_d = stop_q;
      end
    end else begin
      stop_d = stop_d;
    end

    step_d = (state_d == S_STEP_HI) || ((state_d == S_HOMING) && (cnt_d < PULSE_W_C));
    busy_d = (state_d != S_IDLE) && (state_d != S_FAULT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      pos_q       <= 16'd0;
      target_q    <= 16'd0;
      home_cnt_q  <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      enable_q    <= 1'b1;
      busy_q      <= 1'b0;
      homed_q     <= 1'b0;
      fault_q     <= 1'b0;
      limit_hit_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      homing_q    <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      home_cnt_q  <= home_cnt_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      homed_q     <= homed_d;
      fault_q     <= fault_d;
      limit_hit_q <= limit_hit_d;
      cmd_err_q   <= cmd_err_d;
      homing_q    <= homing_d;
      stop_q      <= stop_d;
    end
  end

  assign step   = step_q;
  assign dir    = dir_q;
  assign enable = enable_q;
  assign status = {busy_q, homed_q, fault_q, limit_hit_q, cmd_err_q, 11'd0, pos_q};

endmodule
